// File: rtl/sclk_gen.sv
// Programmable serial-clock generator with edge and word-framing strobes.
// Define SCLK_GEN_WORD_GAP_EN to insert one idle sclk period between back-to-back words.
module sclk_gen #(
  parameter int unsigned DIV_BITS  = 8,
  parameter int unsigned WORD_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_BITS-1:0]  div,
  input  logic                 cpol,
  input  logic [WORD_BITS-1:0] word_len,
  output logic                 sclk,
  output logic                 lead_edge,
  output logic                 trail_edge,
  output logic                 sclk_pos_edge,
  output logic                 sclk_neg_edge,
  output logic                 word_start,
  output logic                 word_done,
  output logic [WORD_BITS-1:0] bit_idx,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StRun, StGap} state_e;

  state_e               state_q, state_d;
  logic [DIV_BITS-1:0]  cnt_q, cnt_d;
  logic [DIV_BITS-1:0]  div_q, div_d;
  logic                 cpol_q, cpol_d;
  logic [WORD_BITS-1:0] wl_q, wl_d;
  logic [WORD_BITS-1:0] bit_q, bit_d;
  logic                 sclk_q, sclk_d;
  logic                 lead_q, lead_d;
  logic                 trail_q, trail_d;
  logic                 pos_q, pos_d;
  logic                 neg_q, neg_d;
  logic                 start_q, start_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 cur_sclk;
  logic                 lead_now;
`ifdef SCLK_GEN_WORD_GAP_EN
  logic [DIV_BITS:0]    gap_q, gap_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    cpol_d   = cpol_q;
    wl_d     = wl_q;
    bit_d    = bit_q;
    sclk_d   = sclk_q;
    lead_d   = 1'b0;
    trail_d  = 1'b0;
    pos_d    = 1'b0;
    neg_d    = 1'b0;
    start_d  = 1'b0;
    done_d   = 1'b0;
    cur_sclk = sclk_q;
    lead_now = 1'b0;
`ifdef SCLK_GEN_WORD_GAP_EN
    gap_d    = gap_q;
`endif

    case (state_q)
      StIdle: begin
        sclk_d = cpol;
        bit_d  = '0;
        cnt_d  = '0;
        if (enable) begin
          state_d = StRun;
          div_d   = div;
          cpol_d  = cpol;
          wl_d    = word_len;
        end
      end

      StRun: begin
        // The cycle showing word_done is the word boundary; enable is sampled at its end.
        if (done_q && !enable) begin
          state_d = StIdle;
          sclk_d  = cpol_q;
        end
`ifdef SCLK_GEN_WORD_GAP_EN
        else if (done_q) begin
          state_d = StGap;
          div_d   = div;
          cpol_d  = cpol;
          wl_d    = word_len;
          sclk_d  = cpol;
          gap_d   = '0;
        end
`endif
        else begin
          if (done_q) begin
            // Re-latch; the new word starts from the new idle level with the counter running.
            div_d    = div;
            cpol_d   = cpol;
            wl_d     = word_len;
            cur_sclk = cpol;
          end
          if (cnt_q == div_d) begin
            cnt_d    = '0;
            sclk_d   = ~cur_sclk;
            lead_now = (cur_sclk == cpol_d);
            lead_d   = lead_now;
            trail_d  = ~lead_now;
            pos_d    = ~cur_sclk;
            neg_d    = cur_sclk;
            start_d  = lead_now && (bit_q == '0);
            if (!lead_now) begin
              if (bit_q == wl_q) begin
                done_d = 1'b1;
                bit_d  = '0;
              end else begin
                bit_d = bit_q + 1'b1;
              end
            end
          end else begin
            cnt_d  = cnt_q + 1'b1;
            sclk_d = cur_sclk;
          end
        end
      end

`ifdef SCLK_GEN_WORD_GAP_EN
      StGap: begin
        sclk_d = cpol_q;
        // Exit edge lands 2*(div+1) cycles after word_done.
        if (gap_q == {div_q, 1'b0}) begin
          cnt_d   = '0;
          gap_d   = '0;
          state_d = enable ? StRun : StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
`endif

      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      div_q   <= '0;
      cpol_q  <= 1'b0;
      wl_q    <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      lead_q  <= 1'b0;
      trail_q <= 1'b0;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SCLK_GEN_WORD_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      cpol_q  <= cpol_d;
      wl_q    <= wl_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      lead_q  <= lead_d;
      trail_q <= trail_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      start_q <= start_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef SCLK_GEN_WORD_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign sclk          = sclk_q;
  assign lead_edge     = lead_q;
  assign trail_edge    = trail_q;
  assign sclk_pos_edge = pos_q;
  assign sclk_neg_edge = neg_q;
  assign word_start    = start_q;
  assign word_done     = done_q;
  assign bit_idx       = bit_q;
  assign busy          = busy_q;

endmodule
